// File: rtl/spi_master_slave.sv
// rtl/spi_master_slave.sv - SPI master and oversampling SPI slave joined point-to-point
// Master drives SClk/MOSI/SS from its Start request; slave answers on MISO.

module spi_master #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [1:0]            MODE,
    input  logic [1:0]            ClkDiv,
    input  logic [DATA_WIDTH-1:0] TxData,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] RxData,
    input  logic                  MISO,
    output logic                  SClk,
    output logic                  MOSI,
    output logic                  SS
);
    localparam int EW = $clog2(2 * DATA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, LEAD, XFER, DONE} state_t;

    state_t                state_q, state_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [EW-1:0]         edge_q, edge_d;
    logic                  cpha_q, cpha_d;
    logic [1:0]            div_q, div_d;
    logic                  sclk_q, sclk_d, ss_q, ss_d, mosi_q, mosi_d, done_q, done_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, rxd_q, rxd_d;
    logic [4:0]            half;
    logic                  leading, last;

    assign half    = 5'd2 << div_q;
    assign leading = ~edge_q[0];
    assign last    = (edge_q == EW'(2 * DATA_WIDTH - 1));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            edge_q  <= '0;
            cpha_q  <= 1'b0;
            div_q   <= '0;
            sclk_q  <= MODE[1];
            ss_q    <= 1'b1;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
            rxd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            edge_q  <= edge_d;
            cpha_q  <= cpha_d;
            div_q   <= div_d;
            sclk_q  <= sclk_d;
            ss_q    <= ss_d;
            mosi_q  <= mosi_d;
            done_q  <= done_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rxd_q   <= rxd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        edge_d  = edge_q;
        cpha_d  = cpha_q;
        div_d   = div_q;
        sclk_d  = sclk_q;
        ss_d    = ss_q;
        mosi_d  = mosi_q;
        done_d  = 1'b0;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rxd_d   = rxd_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    cpha_d  = MODE[0];
                    div_d   = ClkDiv;
                    sclk_d  = MODE[1];
                    tx_d    = TxData;
                    cnt_d   = '0;
                    edge_d  = '0;
                    state_d = LEAD;
                end
            end
            LEAD, XFER: begin
                ss_d = 1'b0;
                if (state_q == LEAD && !cpha_q) begin
                    mosi_d = tx_q[DATA_WIDTH-1];
                end
                // LEAD enters with cnt=0 so its first half-period also covers the SS-fall cycle
                if (cnt_q == half) begin
                    cnt_d   = 5'd1;
                    sclk_d  = ~sclk_q;
                    edge_d  = edge_q + 1'b1;
                    state_d = last ? DONE : XFER;
                    if (leading ^ cpha_q) begin
                        rx_d = {rx_q[DATA_WIDTH-2:0], MISO};
                    end else if (cpha_q || !last) begin
                        tx_d   = tx_q << 1;
                        mosi_d = cpha_q ? tx_q[DATA_WIDTH-1] : tx_q[DATA_WIDTH-2];
                    end
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            DONE: begin
                ss_d    = 1'b1;
                done_d  = 1'b1;
                rxd_d   = rx_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign Done   = done_q;
    assign RxData = rxd_q;
    assign SClk   = sclk_q;
    assign MOSI   = mosi_q;
    assign SS     = ss_q;
endmodule

module spi_slave #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  Clk,
    input  logic [1:0]            MODE,
    input  logic [DATA_WIDTH-1:0] TxData,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] RxData,
    output logic                  MISO,
    input  logic                  SClk,
    input  logic                  MOSI,
    input  logic                  SS
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DATA_WIDTH);

    logic                  sclk_s1_q = 1'b0, sclk_s2_q = 1'b0;
    logic                  ss_s1_q = 1'b0, ss_s2_q = 1'b0;
    logic                  cpol_q = 1'b0, cpha_q = 1'b0, done_q = 1'b0;
    logic [CW-1:0]         cnt_q = '0;
    logic [DATA_WIDTH-1:0] sr_q = '0, rx_q = '0, rxd_q = '0;
    logic                  ss_fall, ss_rise, active, sclk_edge, leading;

    assign ss_fall   = ss_s2_q & ~ss_s1_q;
    assign ss_rise   = ~ss_s2_q & ss_s1_q;
    assign active    = ~ss_s1_q & ~ss_s2_q;
    assign sclk_edge = sclk_s1_q ^ sclk_s2_q;
    assign leading   = sclk_s1_q ^ cpol_q;

    always_ff @(posedge Clk) begin
        sclk_s1_q <= SClk;
        sclk_s2_q <= sclk_s1_q;
        ss_s1_q   <= SS;
        ss_s2_q   <= ss_s1_q;
        done_q    <= 1'b0;
        if (ss_fall) begin
            sr_q   <= TxData;
            cpol_q <= MODE[1];
            cpha_q <= MODE[0];
            cnt_q  <= '0;
        end else if (ss_rise) begin
            if (cnt_q == FULL) begin
                rxd_q  <= rx_q;
                done_q <= 1'b1;
            end
        end else if (active && sclk_edge) begin
            if (leading ^ cpha_q) begin
                rx_q  <= {rx_q[DATA_WIDTH-2:0], MOSI};
                cnt_q <= cnt_q + 1'b1;
            // MSB is already on MISO from SS fall, so the first CPHA=1 leading edge holds it
            end else if (cnt_q != '0 && cnt_q != FULL) begin
                sr_q <= sr_q << 1;
            end
        end
    end

    assign MISO   = SS ? 1'b0 : sr_q[DATA_WIDTH-1];
    assign Done   = done_q;
    assign RxData = rxd_q;
endmodule

module spi_master_slave #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [1:0]            mode_i,
    input  logic [1:0]            clk_div_i,
    input  logic [DATA_WIDTH-1:0] m_tx_data_i,
    input  logic [DATA_WIDTH-1:0] s_tx_data_i,
    output logic                  m_done_o,
    output logic [DATA_WIDTH-1:0] m_rx_data_o,
    output logic                  s_done_o,
    output logic [DATA_WIDTH-1:0] s_rx_data_o,
    output logic                  sclk_o,
    output logic                  mosi_o,
    output logic                  miso_o,
    output logic                  ss_o
);
    spi_master #(.DATA_WIDTH(DATA_WIDTH)) u_master (
        .Clk    (clk_i),
        .Reset  (reset_i),
        .Start  (start_i),
        .MODE   (mode_i),
        .ClkDiv (clk_div_i),
        .TxData (m_tx_data_i),
        .Done   (m_done_o),
        .RxData (m_rx_data_o),
        .MISO   (miso_o),
        .SClk   (sclk_o),
        .MOSI   (mosi_o),
        .SS     (ss_o)
    );

    spi_slave #(.DATA_WIDTH(DATA_WIDTH)) u_slave (
        .Clk    (clk_i),
        .MODE   (mode_i),
        .TxData (s_tx_data_i),
        .Done   (s_done_o),
        .RxData (s_rx_data_o),
        .MISO   (miso_o),
        .SClk   (sclk_o),
        .MOSI   (mosi_o),
        .SS     (ss_o)
    );
endmodule

// File: tb/tb_spi_master_slave.sv
// tb/tb_spi_master_slave.sv - directed-vector bench for spi_master_slave
// Words, Done timing, SClk pulse counts and abort behaviour are checked against hand-derived values.

module tb_spi_master_slave;
    logic       clk = 1'b0;
    logic       reset_i, start_i;
    logic [1:0] mode_i, clk_div_i;
    logic [7:0] m_tx_data_i, s_tx_data_i, m_rx_data_o, s_rx_data_o;
    logic       m_done_o, s_done_o, sclk_o, mosi_o, miso_o, ss_o;

    int checks = 0;
    int failures = 0;
    logic [7:0] last_s_rx;

    spi_master_slave #(.DATA_WIDTH(8)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .mode_i      (mode_i),
        .clk_div_i   (clk_div_i),
        .m_tx_data_i (m_tx_data_i),
        .s_tx_data_i (s_tx_data_i),
        .m_done_o    (m_done_o),
        .m_rx_data_o (m_rx_data_o),
        .s_done_o    (s_done_o),
        .s_rx_data_o (s_rx_data_o),
        .sclk_o      (sclk_o),
        .mosi_o      (mosi_o),
        .miso_o      (miso_o),
        .ss_o        (ss_o)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Start is sampled at posedge 0; n counts posedges after it
    task automatic run_xfer(input string tag, input logic [1:0] mode, input logic [1:0] div,
                            input logic [7:0] mtx, input logic [7:0] stx, input bit extra_start);
        int h, lim, m_cnt, s_cnt, m_at, s_at, pulses;
        logic prev, ss_at1;
        h = 2 << div;
        lim = 2 + 16 * h + 8;
        m_cnt = 0; s_cnt = 0; m_at = -1; s_at = -1; pulses = 0; ss_at1 = 1'b1;
        @(negedge clk);
        mode_i = mode; clk_div_i = div; m_tx_data_i = mtx; s_tx_data_i = stx; start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        prev = mode[1];
        for (int n = 1; n <= lim; n++) begin
            @(posedge clk);
            #1;
            start_i = (extra_start && n == 20) ? 1'b1 : 1'b0;
            if (m_done_o) begin m_cnt++; m_at = n; end
            if (s_done_o) begin s_cnt++; s_at = n; end
            if (sclk_o != prev && sclk_o != mode[1]) pulses++;
            prev = sclk_o;
            if (n == 1) ss_at1 = ss_o;
        end
        check({tag, "_m_rx"}, m_rx_data_o, stx);
        check({tag, "_s_rx"}, s_rx_data_o, mtx);
        check({tag, "_m_done_cnt"}, m_cnt, 1);
        check({tag, "_s_done_cnt"}, s_cnt, 1);
        check({tag, "_m_done_at"}, m_at, 2 + 16 * h);
        check({tag, "_s_done_at"}, s_at, 4 + 16 * h);
        check({tag, "_pulses"}, pulses, 8);
        check({tag, "_ss_low_at1"}, ss_at1, 1'b0);
        check({tag, "_sclk_idle"}, sclk_o, mode[1]);
        last_s_rx = mtx;
    endtask

    initial begin
        int m_cnt, s_cnt, changes;
        logic prev;
        logic [7:0] a, b;
        logic [1:0] md, dv;
        reset_i = 1'b1; start_i = 1'b0; mode_i = 2'b00; clk_div_i = 2'd1;
        m_tx_data_i = 8'h00; s_tx_data_i = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset_i = 1'b0;
        check("rst_ss", ss_o, 1'b1);
        check("rst_sclk", sclk_o, 1'b0);
        check("rst_m_done", m_done_o, 1'b0);
        check("rst_m_rx", m_rx_data_o, 8'h00);
        check("rst_s_done", s_done_o, 1'b0);
        check("rst_s_rx", s_rx_data_o, 8'h00);
        changes = 0; prev = sclk_o;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (sclk_o != prev) changes++;
            prev = sclk_o;
        end
        check("idle_sclk_edges", changes, 0);

        run_xfer("m00", 2'b00, 2'd1, 8'hA5, 8'hD6, 1'b0);
        run_xfer("m01", 2'b01, 2'd1, 8'h3C, 8'h81, 1'b0);
        run_xfer("m10", 2'b10, 2'd1, 8'h5A, 8'h0F, 1'b0);
        run_xfer("m11", 2'b11, 2'd1, 8'hE7, 8'h42, 1'b0);
        run_xfer("restart", 2'b00, 2'd1, 8'h96, 8'h69, 1'b1);

        // abort after three bits: edge 6 lands on posedge 25, reset sampled at posedge 26
        @(negedge clk);
        mode_i = 2'b00; clk_div_i = 2'd1; m_tx_data_i = 8'h3C; s_tx_data_i = 8'hC3; start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        check("abort_ss_before", ss_o, 1'b0);
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        check("abort_ss_after", ss_o, 1'b1);
        check("abort_m_rx", m_rx_data_o, 8'h00);
        m_cnt = 0; s_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (m_done_o) m_cnt++;
            if (s_done_o) s_cnt++;
        end
        check("abort_m_done", m_cnt, 0);
        check("abort_s_done", s_cnt, 0);
        check("abort_s_rx_kept", s_rx_data_o, last_s_rx);

        run_xfer("div2", 2'b00, 2'd2, 8'hFF, 8'h00, 1'b0);

        for (int i = 0; i < 20; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            md = 2'($urandom_range(0, 3));
            dv = 2'($urandom_range(1, 3));
            run_xfer("rand", md, dv, a, b, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
